seg7_capture_decoder: RTL and testbench
=======================================

// Module: seg7_capture_decoder
// PURPOSE
//  Receive-side counterpart of the BCD-to-seven-segment display path: samples four
//  7-segment digit buses (HEX0..HEX3 format), decodes each glyph back to a 4-bit value,
//  debounces by requiring the whole pattern to stay steady, then hands each new stable
//  16-bit word to a consumer over valid/ready. Used as a self-check/loopback monitor
//  behind the lab counters and as the input side of board-to-board segment links.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive equal samples required before a word is committed (>=1)
//  ACTIVE_LOW     1  1: segment lit = 0 (DE-board HEX); 0: segment lit = 1
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst        in   1   asynchronous, active-high reset
//  hex0       in   7   digit 0 segments, bit order {g,f,e,d,c,b,a}
//  hex1       in   7   digit 1 segments
//  hex2       in   7   digit 2 segments
//  hex3       in   7   digit 3 segments
//  out_ready  in   1   consumer accepts word when high with out_valid
//  ovr_clr    in   1   clears sticky ovr (single-cycle pulse)
//  out_data   out  16  {d3,d2,d1,d0} decoded nibbles, d0 from hex0
//  out_err    out  4   per-digit: 1 = glyph not in decode table (nibble forced 0)
//  out_valid  out  1   word available
//  ovr        out  1   sticky: a new stable word was dropped while out_valid held
// BEHAVIOUR
//  - Decode table (active-high view, {g..a}): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//    8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; ACTIVE_LOW inverts inputs before lookup.
//    Any other pattern (incl. blank) -> nibble 0, out_err bit 1.
//  - Pipeline: s_q <= {hex3..hex0} every edge; p_q <= s_q every edge.
//    cnt: s_q!=p_q -> 0; else saturating increment up to STABLE_CYCLES.
//  - FSM: SETTLE (cnt < STABLE_CYCLES), IDLE (stable, word already reported),
//    OFFER (out_valid=1). Commit condition at an edge: cnt becomes STABLE_CYCLES
//    AND (nothing reported since reset OR decoded word+err != last reported).
//    On commit from SETTLE/IDLE -> OFFER: out_data/out_err loaded, last_rep updated.
//  - Latency: inputs change then hold -> out_valid high after STABLE_CYCLES+2 edges.
//  - Handshake: out_valid && out_ready at edge -> transfer, out_valid drops next cycle
//    (back-to-back only if a commit coincides; then OFFER stays with new word).
//    out_data/out_err stable while out_valid && !out_ready.
//  - Commit while OFFER and !out_ready: new word dropped, ovr <= 1, last_rep NOT
//    updated (word will re-commit only after a further change). Commit and ovr_clr
//    same edge: ovr ends 1 (set wins).
//  - Same stable pattern returning after a glitch shorter than STABLE_CYCLES: no report.
//  - Glitch resets cnt; any pattern change restarts settle regardless of FSM state.
//  - Reset (async, any time incl. mid-OFFER): out_valid=0, out_data=0, out_err=0,
//    ovr=0, cnt=0, s_q/p_q=all-segments-off pattern, reported-flag cleared, FSM=SETTLE.
//    Pending word is discarded; first stable word after reset is always reported.
// TESTING
//  1 Reset, hold hex3..0 = "1","2","3","4" (ACTIVE_LOW: 79,24,30,19), ready=1 ->
//    out_valid after 6 edges, out_data=16'h1234, out_err=0, one-cycle valid.
//  2 Same inputs held 100 cycles after transfer -> no further out_valid.
//  3 Toggle hex0 to "5" for 2 cycles then back -> no report; hold "5" -> 16'h1235.
//  4 hex2 = 7'h7F (blank, active-low), others "0" -> out_data=0, out_err=4'b0100.
//  5 ready=0, word A offered, then stable word B -> A held unchanged, ovr=1;
//    ovr_clr pulse -> ovr=0; ready=1 -> A transferred, no B until inputs change.
//  6 Assert rst during OFFER -> out_valid/out_data/ovr 0 immediately (async);
//    release -> current stable word re-reported after STABLE_CYCLES+2 edges.

Source files
------------

// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder: decodes four 7-segment digit buses back to nibbles, debounces
// the whole pattern and offers each new stable 16-bit word over valid/ready.
module seg7_capture_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  hex0,
  input  logic [6:0]  hex1,
  input  logic [6:0]  hex2,
  input  logic [6:0]  hex3,
  input  logic        out_ready,
  input  logic        ovr_clr,
  output logic [15:0] out_data,
  output logic [3:0]  out_err,
  output logic        out_valid,
  output logic        ovr
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] N = CW'(STABLE_CYCLES);
  localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;
  typedef enum logic [1:0] {SETTLE, IDLE, OFFER} state_t;
  state_t state, state_n;
  logic [27:0] s_q, p_q;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0] dec_data;
  logic [3:0] dec_err;
  logic [19:0] last_rep;
  logic rep, commit, take;

  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [6:0] a;
    a = ACTIVE_LOW ? ~seg : seg;
    case (a)
      7'h3F: decode = 5'h00;
      7'h06: decode = 5'h01;
      7'h5B: decode = 5'h02;
      7'h4F: decode = 5'h03;
      7'h66: decode = 5'h04;
      7'h6D: decode = 5'h05;
      7'h7D: decode = 5'h06;
      7'h07: decode = 5'h07;
      7'h7F: decode = 5'h08;
      7'h6F: decode = 5'h09;
      7'h77: decode = 5'h0A;
      7'h7C: decode = 5'h0B;
      7'h39: decode = 5'h0C;
      7'h5E: decode = 5'h0D;
      7'h79: decode = 5'h0E;
      7'h71: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_dec
    assign {dec_err[i], dec_data[4*i +: 4]} = decode(s_q[7*i +: 7]);
  end

  // A commit fires once per stable run; a repeat of the last reported word is suppressed
  always_comb begin
    cnt_n = (s_q != p_q) ? '0 : (cnt == N) ? cnt : cnt + 1'b1;
    commit = (cnt_n == N) && (cnt != N) && (!rep || {dec_err, dec_data} != last_rep);
    take = commit && (state != OFFER || out_ready);
    state_n = (take || (state == OFFER && !out_ready)) ? OFFER : (cnt_n == N) ? IDLE : SETTLE;
  end

  assign out_valid = state == OFFER;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SETTLE;
      s_q <= {4{BLANK}};
      p_q <= {4{BLANK}};
      cnt <= '0;
      rep <= 1'b0;
      last_rep <= '0;
      out_data <= '0;
      out_err <= '0;
      ovr <= 1'b0;
    end else begin
      state <= state_n;
      s_q <= {hex3, hex2, hex1, hex0};
      p_q <= s_q;
      cnt <= cnt_n;
      if (take) begin
        out_data <= dec_data;
        out_err <= dec_err;
        last_rep <= {dec_err, dec_data};
        rep <= 1'b1;
      end
      ovr <= (commit && !take) ? 1'b1 : ovr_clr ? 1'b0 : ovr;
    end
  end
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// tb_seg7_capture_decoder: randomized and directed stimulus against a run-length
// reference model; a negedge monitor compares DUT output with a queue of expected words.
module tb_seg7_capture_decoder;
  localparam int N = 4;
  logic clk = 0, rst = 1;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic out_ready = 1, ovr_clr = 0;
  logic [15:0] out_data;
  logic [3:0] out_err;
  logic out_valid, ovr;
  int errors = 0, checks = 0;
  logic [19:0] exp_q[$];
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [15:0] pool [4] = '{16'h1234, 16'hBEEF, 16'h0C0D, 16'h9999};

  always #5 clk = ~clk;

  seg7_capture_decoder #(.STABLE_CYCLES(N), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .out_ready(out_ready), .ovr_clr(ovr_clr), .out_data(out_data), .out_err(out_err),
    .out_valid(out_valid), .ovr(ovr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] raw);
    for (int i = 0; i < 16; i++) if (~raw == glyph[i]) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  function automatic logic [19:0] ref_word(input logic [27:0] p);
    logic [19:0] w;
    logic [4:0] d;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      d = ref_decode(p[7*i +: 7]);
      w[16+i] = d[4];
      w[4*i +: 4] = d[3:0];
    end
    return w;
  endfunction

  // Reference: a word is committed once its run of identical samples reaches N+1
  logic [27:0] m_last = '1, m_sv = '1;
  int m_run = 1;
  logic m_rep = 0, m_ovr = 0;
  logic [19:0] m_lastrep = '0, m_w;
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_last = '1; m_sv = '1; m_run = 1; m_rep = 0; m_ovr = 0;
      exp_q.delete();
    end else begin
      if (m_sv == m_last) m_run++;
      else begin m_last = m_sv; m_run = 1; end
      m_w = ref_word(m_last);
      if (m_run == N + 1 && (!m_rep || m_w != m_lastrep)) begin
        if (exp_q.size() > 0) m_ovr = 1;
        else begin exp_q.push_back(m_w); m_lastrep = m_w; m_rep = 1; end
      end else if (ovr_clr) m_ovr = 0;
      m_sv = {hex3, hex2, hex1, hex0};
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("valid", out_valid, exp_q.size() > 0);
      check("ovr", ovr, m_ovr);
      if (exp_q.size() > 0) begin
        check("word", {out_err, out_data}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic set_digits(input logic [15:0] v);
    hex0 = ~glyph[v[3:0]];
    hex1 = ~glyph[v[7:4]];
    hex2 = ~glyph[v[11:8]];
    hex3 = ~glyph[v[15:12]];
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic latency(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #2; n++; end
    check(name, n, N + 2);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 30) begin @(posedge clk); #2; n++; end
    check(name, out_valid, 1);
  endtask

  initial begin
    set_digits(16'h1234);
    #7;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_err", out_err, 0);
    check("rst_ovr", ovr, 0);
    #5 rst = 0;
    latency("latency1");
    check("data1234", out_data, 16'h1234);
    check("err1234", out_err, 0);
    cycles(1);
    check("one_cycle", out_valid, 0);
    cycles(100);
    set_digits(16'h1235); cycles(2);
    set_digits(16'h1234); cycles(12);
    set_digits(16'h1235);
    wait_valid("v1235");
    check("data1235", out_data, 16'h1235);
    cycles(3);
    set_digits(16'h0000); hex2 = 7'h7F;
    wait_valid("vblank");
    check("blank_data", out_data, 0);
    check("blank_err", out_err, 4'b0100);
    cycles(3);
    out_ready = 0;
    set_digits(16'hA5A5);
    wait_valid("vA");
    set_digits(16'h5A5A); cycles(10);
    check("ovr_set", ovr, 1);
    check("held_A", out_data, 16'hA5A5);
    ovr_clr = 1; cycles(1); ovr_clr = 0;
    check("ovr_clr", ovr, 0);
    out_ready = 1; cycles(20);
    set_digits(16'h0F0F); cycles(10);
    set_digits(16'h5A5A); cycles(10);
    out_ready = 0;
    set_digits(16'h9876);
    wait_valid("v9876");
    set_digits(16'h1111); cycles(8);
    check("ovr_pre_rst", ovr, 1);
    rst = 1; #1;
    check("async_valid", out_valid, 0);
    check("async_data", out_data, 0);
    check("async_ovr", ovr, 0);
    #4 rst = 0; out_ready = 1;
    latency("latency_rerep");
    check("rerep_data", out_data, 16'h1111);
    cycles(3);
    for (int k = 0; k < 300; k++) begin
      set_digits(pool[$urandom_range(0, 3)]);
      if ($urandom_range(0, 4) == 0) hex1 = 7'($urandom);
      repeat ($urandom_range(1, 9)) begin
        out_ready = $urandom_range(0, 3) != 0;
        ovr_clr = $urandom_range(0, 7) == 0;
        cycles(1);
      end
    end
    out_ready = 1; ovr_clr = 0;
    cycles(20);
    check("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
